locking_rr_arbiter: RTL and testbench
=====================================

# locking_rr_arbiter

Parametrised N-input locking arbiter for the TileLink grant/data channels of the AXI4 bridge. It generalises the fixed two-input, fixed-priority locking arbiter to N_IN inputs and a configurable burst length. It adds a selectable round-robin mode and a lock-status output. A multibeat message keeps its grant until the last beat is accepted, so beats from different sources never interleave at the output.

## Interface
- N_IN, 2: number of input channels; legal range 2..8.
- DATA_W, 64: payload width per channel; opaque to the arbiter.
- BEATS, 8: beats per data-carrying message; power of two, at least 2.
- RR, 1: 0 = fixed priority (lowest index wins); 1 = round-robin.
- Derived: IW = clog2(N_IN); CW = clog2(BEATS).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- io_in_valid  in  N_IN  per-channel valid.
- io_in_ready  out  N_IN  per-channel ready.
- io_in_has_data  in  N_IN  1 = the message carries BEATS beats and locks the arbiter.
- io_in_data  in  N_IN*DATA_W  payloads; channel i occupies bits [i*DATA_W +: DATA_W].
- io_out_valid  out  1  output valid.
- io_out_ready  in  1  downstream ready.
- io_out_data  out  DATA_W  payload of the chosen channel.
- io_out_has_data  out  1  has_data bit of the chosen channel.
- io_chosen  out  IW  index of the channel currently routed to the output.
- io_locked  out  1  a multibeat message is in progress.

## Operation
- State registers:
  - beat_cnt (CW bits, reset 0).
  - lock_idx (IW bits, reset 0).
  - rr_ptr (IW bits, reset N_IN-1), holding the last channel that completed a message.
- locked = (beat_cnt != 0); io_locked = locked.
- Unlocked selection:
  - RR=0: the lowest index with valid=1.
  - RR=1: the first index with valid=1 searching rr_ptr+1, rr_ptr+2, … modulo N_IN.
  - No channel valid: choice = 0.
- io_chosen = locked ? lock_idx : choice.
- Output muxing:
  - io_out_valid = io_in_valid[io_chosen].
  - io_out_data = io_in_data[io_chosen].
  - io_out_has_data = io_in_has_data[io_chosen].
- io_in_ready[i] = io_out_ready & (i == io_chosen). Only the chosen channel ever sees ready.
- fire = io_out_valid & io_out_ready.
- On fire with io_out_has_data=1:
  - beat_cnt <= beat_cnt + 1, truncated to CW bits, so it wraps to 0 after BEATS beats.
  - lock_idx <= io_chosen.
- On fire with has_data=0: beat_cnt unchanged. Single-beat messages never lock.
- Message completes on fire & (!io_out_has_data | beat_cnt == BEATS-1).
  - RR=1: rr_ptr <= io_chosen on completion.
  - RR=0: rr_ptr is held at its reset value.
- Locked channel drops valid mid-burst: io_out_valid=0 and the lock is held. No other channel is granted until the remaining beats complete.
- has_data is sampled per beat. Beats of a locked message must all present has_data=1; behaviour is otherwise undefined and is flagged by an assertion in simulation.
- Reset mid-burst: beat_cnt=0, lock released, rr_ptr=N_IN-1. In-flight beats are abandoned.

## Timing
- Request-to-grant latency is zero: io_in_valid → io_chosen → io_in_ready/io_out_* is a purely combinational path.
- Lock, counter and pointer changes take effect the cycle after the causing fire.
- Outputs during and just after reset:
  - io_locked=0.
  - io_chosen = choice, which equals 0 when no input is valid.
  - io_out_valid follows input 0's valid when nothing else is valid.
- Throughput: one beat per cycle while io_out_ready=1.
- A new message may win the cycle immediately after the previous message's last beat.
- Arbitration never changes inside a locked burst, regardless of ready or valid gaps.

## Test plan
- Fixed priority: RR=0, N_IN=4, channels 1 and 3 valid with has_data=0 → io_chosen=1, io_in_ready=4'b0010; drop channel 1 → io_chosen=3.
- Lock hold: BEATS=8, channel 2 sends has_data=1 while channel 0 is valid throughout → 8 consecutive output beats all from channel 2, io_locked=1 after the first beat, channel 0 granted on cycle 9.
- Round-robin fairness: RR=1, N_IN=4, all channels valid with single-beat messages and out_ready=1 → grant sequence 0,1,2,3,0,1.
- Backpressure and valid gaps: mid-burst, toggle out_ready and drop the locked channel's valid for 3 cycles → no beat lost or duplicated, lock_idx unchanged, beat_cnt resumes at the correct value.
- Reset mid-burst: assert reset at beat 4 of 8 → next cycle io_locked=0, beat_cnt=0, RR grant order restarts at channel 0.
- Width and wrap sweep: N_IN=2,3,8 and BEATS=2,16 → counter wraps exactly after BEATS beats, and the non-power-of-two N_IN RR pointer wraps from N_IN-1 to 0.

Source files
------------

// File: rtl/locking_rr_arbiter.sv
`default_nettype none
// ============================================================================
// locking_rr_arbiter : N-input locking arbiter (fixed priority / round-robin)
// Revision: 1.0
// ============================================================================
module locking_rr_arbiter #(
  parameter int N_IN   = 2,
  parameter int DATA_W = 64,
  parameter int BEATS  = 8,
  parameter int RR     = 1,
  localparam int IW    = $clog2(N_IN),
  localparam int CW    = $clog2(BEATS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_IN-1:0]        io_in_valid,
  output logic [N_IN-1:0]        io_in_ready,
  input  logic [N_IN-1:0]        io_in_has_data,
  input  logic [N_IN*DATA_W-1:0] io_in_data,
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic [DATA_W-1:0]      io_out_data,
  output logic                   io_out_has_data,
  output logic [IW-1:0]          io_chosen,
  output logic                   io_locked
);

  localparam logic [IW-1:0] C_LAST_IDX  = IW'(N_IN - 1);
  localparam logic [CW-1:0] C_LAST_BEAT = CW'(BEATS - 1);

  logic [CW-1:0]     beat_cnt_q, beat_cnt_d;
  logic [IW-1:0]     lock_idx_q, lock_idx_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     choice;
  logic [IW-1:0]     search_idx;
  logic              search_found;
  logic              locked;
  logic              fire;
  logic              last_beat;
  logic [DATA_W-1:0] data_arr [N_IN];

  for (genvar i = 0; i < N_IN; i++) begin : g_chan
    assign data_arr[i]    = io_in_data[i*DATA_W +: DATA_W];
    assign io_in_ready[i] = io_out_ready & (io_chosen == IW'(i));
  end

  // Round-robin starts one past the last completed channel; fixed priority from 0.
  always_comb begin
    choice       = '0;
    search_idx   = '0;
    search_found = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      if (RR != 0) begin
        search_idx = IW'((int'(rr_ptr_q) + 1 + k) % N_IN);
      end else begin
        search_idx = IW'(k);
      end
      if (!search_found && io_in_valid[search_idx]) begin
        choice       = search_idx;
        search_found = 1'b1;
      end
    end
  end

  assign locked          = (beat_cnt_q != '0);
  assign io_locked       = locked;
  assign io_chosen       = locked ? lock_idx_q : choice;
  assign io_out_valid    = io_in_valid[io_chosen];
  assign io_out_has_data = io_in_has_data[io_chosen];
  assign io_out_data     = data_arr[io_chosen];
  assign fire            = io_out_valid & io_out_ready;
  assign last_beat       = !io_out_has_data | (beat_cnt_q == C_LAST_BEAT);

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    if (fire && io_out_has_data) begin
      beat_cnt_d = beat_cnt_q + CW'(1);
      lock_idx_d = io_chosen;
    end
    if (fire && last_beat && (RR != 0)) begin
      rr_ptr_d = io_chosen;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt_q <= '0;
      lock_idx_q <= '0;
      rr_ptr_q   <= C_LAST_IDX;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Every beat of a locked message must carry data.
  a_locked_beat_has_data: assert property (
    @(posedge clk) disable iff (reset) (locked && fire) |-> io_out_has_data
  );

endmodule
`default_nettype wire

// File: tb/tb_locking_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_locking_rr_arbiter : five arbiter configurations under random traffic,
// each compared every cycle with a message-level reference model.
// Revision: 1.0
// ============================================================================
module tb_locking_rr_arbiter;

  localparam int NDUT = 5;
  localparam int DW   = 16;
  localparam int NCYC = 4000;

  function automatic int n_of(int g);
    case (g)
      0, 1:    return 4;
      2:       return 3;
      3:       return 8;
      default: return 2;
    endcase
  endfunction

  function automatic int beats_of(int g);
    case (g)
      0, 1:    return 8;
      2:       return 2;
      default: return 16;
    endcase
  endfunction

  function automatic int rr_of(int g);
    return (g == 1) ? 0 : 1;
  endfunction

  logic clk = 1'b0;
  logic rst;

  logic [7:0]      vld  [NDUT];
  logic [7:0]      hd   [NDUT];
  logic [8*DW-1:0] dat  [NDUT];
  logic [NDUT-1:0] ordy;

  wire [7:0]       rdy_o [NDUT];
  wire [2:0]       ch_o  [NDUT];
  wire [DW-1:0]    od_o  [NDUT];
  wire [NDUT-1:0]  ov_o;
  wire [NDUT-1:0]  ohd_o;
  wire [NDUT-1:0]  lk_o;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int N   = n_of(g);
    localparam int IWG = $clog2(N);
    wire [N-1:0]   rdy_w;
    wire [IWG-1:0] ch_w;

    locking_rr_arbiter #(
      .N_IN  (N),
      .DATA_W(DW),
      .BEATS (beats_of(g)),
      .RR    (rr_of(g))
    ) u_dut (
      .clk            (clk),
      .reset          (rst),
      .io_in_valid    (vld[g][N-1:0]),
      .io_in_ready    (rdy_w),
      .io_in_has_data (hd[g][N-1:0]),
      .io_in_data     (dat[g][N*DW-1:0]),
      .io_out_valid   (ov_o[g]),
      .io_out_ready   (ordy[g]),
      .io_out_data    (od_o[g]),
      .io_out_has_data(ohd_o[g]),
      .io_chosen      (ch_w),
      .io_locked      (lk_o[g])
    );

    assign rdy_o[g] = 8'(rdy_w);
    assign ch_o[g]  = 3'(ch_w);
  end

  // Reference model: who owns the output, how many beats of its message
  // have gone, and which channel finished a message most recently.
  int       m_owner [NDUT];
  int       m_sent  [NDUT];
  int       m_last  [NDUT];
  bit [7:0] done_pend [NDUT];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_choice(int g);
    int n = n_of(g);
    if (m_sent[g] != 0) return m_owner[g];
    for (int k = 1; k <= n; k++) begin
      int c = (rr_of(g) != 0) ? (m_last[g] + k) % n : k - 1;
      if (vld[g][c]) return c;
    end
    return 0;
  endfunction

  task automatic model_reset(int g);
    m_sent[g]  = 0;
    m_owner[g] = 0;
    m_last[g]  = n_of(g) - 1;
  endtask

  task automatic check_dut(int g);
    int c;
    logic [7:0] er;
    c  = exp_choice(g);
    er = '0;
    if (ordy[g]) er[c] = 1'b1;
    chk($sformatf("g%0d chosen", g),       64'(ch_o[g]),  64'(c));
    chk($sformatf("g%0d locked", g),       64'(lk_o[g]),  64'(m_sent[g] != 0));
    chk($sformatf("g%0d out_valid", g),    64'(ov_o[g]),  64'(vld[g][c]));
    chk($sformatf("g%0d out_has_data", g), 64'(ohd_o[g]), 64'(hd[g][c]));
    chk($sformatf("g%0d out_data", g),     64'(od_o[g]),  64'(dat[g][c*DW +: DW]));
    chk($sformatf("g%0d in_ready", g),     64'(rdy_o[g]), 64'(er));
  endtask

  task automatic model_step(int g);
    int c;
    bit fire;
    bit last;
    if (rst) begin
      model_reset(g);
      return;
    end
    c    = exp_choice(g);
    fire = vld[g][c] && ordy[g];
    if (!fire) return;
    last = !hd[g][c] || (m_sent[g] + 1 == beats_of(g));
    if (hd[g][c]) begin
      m_owner[g] = c;
      m_sent[g]  = last ? 0 : m_sent[g] + 1;
    end
    if (last) begin
      if (rr_of(g) != 0) m_last[g] = c;
      done_pend[g][c] = 1'b1;
    end
  endtask

  // A channel picks a fresh has_data only once its previous message is done,
  // so a locked burst always presents has_data=1.
  task automatic drive(int cyc);
    for (int g = 0; g < NDUT; g++) begin
      ordy[g] = (cyc < 200) ? 1'b1 : ($urandom_range(0, 3) != 0);
      for (int c = 0; c < n_of(g); c++) begin
        vld[g][c] = (cyc < 200) ? 1'b1 : ($urandom_range(0, 99) < 65);
        dat[g][c*DW +: DW] = DW'($urandom);
        if (done_pend[g][c]) begin
          hd[g][c]        = (cyc >= 60) && ($urandom_range(0, 1) == 1);
          done_pend[g][c] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    ordy = '0;
    for (int g = 0; g < NDUT; g++) begin
      vld[g]       = '0;
      hd[g]        = '0;
      dat[g]       = '0;
      done_pend[g] = '1;
      model_reset(g);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      rst = ((cyc % 700) == 650);
      drive(cyc);
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
        if (!rst) check_dut(g);
        model_step(g);
      end
      @(posedge clk);
      #1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
